if_fetch_stage: RTL and testbench

Instruction-fetch stage sitting directly downstream of the PC register (Reg_PC) in the MIPS datapath. Takes the current PC, runs a request/ready handshake with instruction memory, and delivers {pc, pc+4, instruction} into the IF/ID pipeline register. Drives a hold signal back to the PC register so the PC advances only when a fetch completes. Supports decode back-pressure through a one-entry hold buffer, and branch flush.

---
 rtl/if_fetch_stage.sv | 185 ++++++++++++++++++
 tb/tb_if_fetch_stage.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: takes the PC, runs a request/ready handshake with
// instruction memory, and delivers {pc, pc+4, instr} into the IF/ID register.
// A one-entry hold buffer absorbs a word that completes while decode is stalled.
// A flush kills both IF/ID and the hold buffer. A request already in flight is
// drained through DISCARD with its address held stable.
//
// Handshake semantics:
//   memory side: a transfer completes on any edge where imem_req=1 and
//   imem_ready=1. While imem_req=1 and imem_ready=0 the address is stable.
//   decode side: IF/ID is consumed on any edge where ifid_valid=1 and
//   id_stall=0. A flush on the same edge takes priority.
module if_fetch_stage #(
  parameter logic RESET_PC_HOLD = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_in,
  output logic        pc_hold,
  input  logic        flush,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  input  logic        id_stall,
  output logic        ifid_valid,
  output logic [31:0] ifid_pc,
  output logic [31:0] ifid_pc4,
  output logic [31:0] ifid_instr,
  output logic [1:0]  dbg_state,
  output logic        dbg_hb_valid
);

  // Debug encoding visible on dbg_state: 0=IDLE 1=FETCH 2=HOLD 3=DISCARD
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_FETCH   = 2'd1,
    S_HOLD    = 2'd2,
    S_DISCARD = 2'd3
  } state_t;

  state_t      state;
  state_t      state_nxt;

  // Address of the most recent FETCH request. DISCARD replays it to memory.
  logic [31:0] req_addr;

  logic        hb_valid;
  logic [31:0] hb_pc;
  logic [31:0] hb_pc4;
  logic [31:0] hb_instr;

  logic        flush_kill;     // clear IF/ID and hold buffer this edge
  logic        load_ifid_mem;  // IF/ID <= fresh memory word
  logic        load_ifid_hb;   // IF/ID <= hold buffer
  logic        load_hb;        // hold buffer <= fresh memory word
  logic        bubble;         // IF/ID consumed with nothing to replace it
  logic [31:0] pc_plus4;

  // Wraps modulo 2^32 and has no alignment check.
  assign pc_plus4     = pc_in + 32'd4;
  assign dbg_state    = state;
  assign dbg_hb_valid = hb_valid;

  // Next-state, memory request, PC hold and datapath load enables
  always_comb begin
    state_nxt     = state;
    imem_req      = 1'b0;
    imem_addr     = req_addr;
    pc_hold       = 1'b1;
    flush_kill    = 1'b0;
    load_ifid_mem = 1'b0;
    load_ifid_hb  = 1'b0;
    load_hb       = 1'b0;
    bubble        = 1'b0;
    case (state)
      S_IDLE: begin
        pc_hold    = RESET_PC_HOLD;
        flush_kill = flush;
        state_nxt  = S_FETCH;
      end
      S_FETCH: begin
        imem_req  = 1'b1;
        imem_addr = pc_in;
        if (flush) begin
          // A completing word is dropped. Otherwise drain the open request.
          flush_kill = 1'b1;
          state_nxt  = imem_ready ? S_FETCH : S_DISCARD;
        end else if (imem_ready) begin
          pc_hold = 1'b0;
          if (!ifid_valid || !id_stall) begin
            load_ifid_mem = 1'b1;
          end else begin
            load_hb   = 1'b1;
            state_nxt = S_HOLD;
          end
        end else if (!id_stall) begin
          bubble = 1'b1;
        end
      end
      S_HOLD: begin
        if (flush) begin
          flush_kill = 1'b1;
          state_nxt  = S_FETCH;
        end else if (!id_stall) begin
          load_ifid_hb = 1'b1;
          state_nxt    = S_FETCH;
        end
      end
      S_DISCARD: begin
        // The stale request stays on the bus until memory answers.
        imem_req = 1'b1;
        if (flush) begin
          flush_kill = 1'b1;
        end else if (imem_ready) begin
          state_nxt = S_FETCH;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Capture the request address on every FETCH cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_addr <= 32'd0;
    end else if (state == S_FETCH) begin
      req_addr <= pc_in;
    end
  end

  // IF/ID pipeline register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ifid_valid <= 1'b0;
      ifid_pc    <= 32'd0;
      ifid_pc4   <= 32'd0;
      ifid_instr <= 32'd0;
    end else if (flush_kill) begin
      ifid_valid <= 1'b0;
    end else if (load_ifid_mem) begin
      ifid_valid <= 1'b1;
      ifid_pc    <= pc_in;
      ifid_pc4   <= pc_plus4;
      ifid_instr <= imem_rdata;
    end else if (load_ifid_hb) begin
      ifid_valid <= 1'b1;
      ifid_pc    <= hb_pc;
      ifid_pc4   <= hb_pc4;
      ifid_instr <= hb_instr;
    end else if (bubble) begin
      ifid_valid <= 1'b0;
    end
  end

  // One-entry hold buffer for a word that arrives while decode is stalled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hb_valid <= 1'b0;
      hb_pc    <= 32'd0;
      hb_pc4   <= 32'd0;
      hb_instr <= 32'd0;
    end else if (flush_kill) begin
      hb_valid <= 1'b0;
    end else if (load_hb) begin
      hb_valid <= 1'b1;
      hb_pc    <= pc_in;
      hb_pc4   <= pc_plus4;
      hb_instr <= imem_rdata;
    end else if (load_ifid_hb) begin
      hb_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage. The PC register and instruction memory are modelled
// here. Every word memory returns for a live (non-flushed) request is pushed as
// {pc, pc+4, word} into an expected queue. The negedge monitor pops one entry
// each time decode consumes IF/ID and compares it field by field.
module tb_if_fetch_stage;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_FETCH   = 2'd1;
  localparam logic [1:0] ST_HOLD    = 2'd2;
  localparam logic [1:0] ST_DISCARD = 2'd3;

  localparam int RDY_NEVER  = 0;
  localparam int RDY_ALWAYS = 1;
  localparam int RDY_RAND   = 2;
  localparam int RDY_FORCE  = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_in;
  logic        pc_hold;
  logic        flush;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        id_stall;
  logic        ifid_valid;
  logic [31:0] ifid_pc;
  logic [31:0] ifid_pc4;
  logic [31:0] ifid_instr;
  logic [1:0]  dbg_state;
  logic        dbg_hb_valid;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [95:0] exp_q[$];
  logic        stale      = 1'b0;
  logic [31:0] stale_addr = 32'd0;

  if_fetch_stage #(.RESET_PC_HOLD(1'b1)) dut (
    .clk          (clk),
    .rst          (rst),
    .pc_in        (pc_in),
    .pc_hold      (pc_hold),
    .flush        (flush),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ready   (imem_ready),
    .imem_rdata   (imem_rdata),
    .id_stall     (id_stall),
    .ifid_valid   (ifid_valid),
    .ifid_pc      (ifid_pc),
    .ifid_pc4     (ifid_pc4),
    .ifid_instr   (ifid_instr),
    .dbg_state    (dbg_state),
    .dbg_hb_valid (dbg_hb_valid)
  );

  // Clock: 20 time-unit period
  always #10 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Instruction memory contents
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h2008_0001;
      32'h0000_0004: return 32'h2009_0002;
      32'h0000_0008: return 32'h0109_5020;
      32'h0000_0200: return 32'hDEAD_BEEF;
      default:       return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0000;
    endcase
  endfunction

  task automatic check_reset(input string tag);
    chk({tag, "_imem_req"},   32'(imem_req),   32'd0);
    chk({tag, "_imem_addr"},  imem_addr,       32'd0);
    chk({tag, "_pc_hold"},    32'(pc_hold),    32'd1);
    chk({tag, "_ifid_valid"}, 32'(ifid_valid), 32'd0);
    chk({tag, "_ifid_pc"},    ifid_pc,         32'd0);
    chk({tag, "_ifid_pc4"},   ifid_pc4,        32'd0);
    chk({tag, "_ifid_instr"}, ifid_instr,      32'd0);
    chk({tag, "_state"},      32'(dbg_state),  32'(ST_IDLE));
    chk({tag, "_hb_valid"},   32'(dbg_hb_valid), 32'd0);
  endtask

  // Driver: one clock cycle. Called just after a rising edge. Drives flush and
  // stall, lets memory answer, then models the PC register at the next edge.
  task automatic cycle(input logic fl, input logic [31:0] tgt, input logic stall,
                       input int rmode);
    logic hold_s;
    flush    = fl;
    id_stall = stall;
    #2;
    case (rmode)
      RDY_NEVER:  imem_ready = 1'b0;
      RDY_ALWAYS: imem_ready = imem_req;
      RDY_FORCE:  imem_ready = 1'b1;
      default:    imem_ready = imem_req && ($urandom_range(0, 1) == 1);
    endcase
    imem_rdata = imem_ready ? mem_word(imem_addr) : $urandom();
    #2;
    hold_s = pc_hold;
    @(posedge clk);
    #1;
    if (rst)          pc_in = 32'd0;
    else if (fl)      pc_in = tgt;
    else if (!hold_s) pc_in = pc_in + 32'd4;
  endtask

  // Scoreboard monitor: samples mid-cycle, before the upcoming edge
  always @(negedge clk) begin : monitor
    logic [95:0] e;
    logic        hs;
    if (rst) begin
      exp_q.delete();
      stale = 1'b0;
    end else begin
      chk("ifid_valid", 32'(ifid_valid), 32'(exp_q.size() != 0));
      if (ifid_valid && !id_stall && !flush && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("ifid_pc",    ifid_pc,    e[95:64]);
        chk("ifid_pc4",   ifid_pc4,   e[63:32]);
        chk("ifid_instr", ifid_instr, e[31:0]);
      end
      hs = imem_req && imem_ready;
      if (imem_req) chk("imem_addr", imem_addr, stale ? stale_addr : pc_in);
      chk("pc_hold", 32'(pc_hold), 32'(!(hs && !flush && !stale)));
      if (hs && stale) begin
        stale = 1'b0;
      end else if (hs && !flush) begin
        exp_q.push_back({pc_in, pc_in + 32'd4, mem_word(pc_in)});
      end
      if (flush) begin
        exp_q.delete();
        if (imem_req && !imem_ready && !stale) begin
          stale      = 1'b1;
          stale_addr = pc_in;
        end
      end
    end
  end

  initial begin
    rst        = 1'b1;
    pc_in      = 32'd0;
    flush      = 1'b0;
    id_stall   = 1'b0;
    imem_ready = 1'b0;
    imem_rdata = 32'd0;
    @(posedge clk);
    #2;
    check_reset("rst");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Zero-wait stream 0x0, 0x4, 0x8 (first cycle is IDLE)
    repeat (4) cycle(1'b0, 32'd0, 1'b0, RDY_ALWAYS);

    // Wait states at 0x40: ready on the third request cycle
    cycle(1'b1, 32'h40, 1'b0, RDY_ALWAYS);
    cycle(1'b0, 32'd0, 1'b0, RDY_NEVER);
    cycle(1'b0, 32'd0, 1'b0, RDY_NEVER);
    cycle(1'b0, 32'd0, 1'b0, RDY_ALWAYS);

    // Back-pressure: 0x100 in IF/ID, 0x104 completes while stalled
    cycle(1'b1, 32'h100, 1'b0, RDY_ALWAYS);
    cycle(1'b0, 32'd0, 1'b0, RDY_ALWAYS);
    cycle(1'b0, 32'd0, 1'b1, RDY_ALWAYS);
    #2;
    chk("bp_state",    32'(dbg_state),    32'(ST_HOLD));
    chk("bp_imem_req", 32'(imem_req),     32'd0);
    chk("bp_ifid_pc",  ifid_pc,           32'h100);
    chk("bp_hb_valid", 32'(dbg_hb_valid), 32'd1);
    cycle(1'b0, 32'd0, 1'b1, RDY_ALWAYS);
    cycle(1'b0, 32'd0, 1'b0, RDY_ALWAYS);
    #2;
    chk("bp_rel_pc",   ifid_pc,   32'h104);
    chk("bp_rel_pc4",  ifid_pc4,  32'h108);
    chk("bp_rel_addr", imem_addr, 32'h108);

    // Flush while the request at 0x200 waits; redirect to 0x400
    cycle(1'b1, 32'h200, 1'b0, RDY_ALWAYS);
    cycle(1'b1, 32'h400, 1'b0, RDY_NEVER);
    #2;
    chk("fl_state", 32'(dbg_state), 32'(ST_DISCARD));
    chk("fl_addr",  imem_addr,      32'h200);
    cycle(1'b0, 32'd0, 1'b0, RDY_NEVER);
    cycle(1'b0, 32'd0, 1'b0, RDY_ALWAYS);
    #2;
    chk("fl_after_state", 32'(dbg_state),  32'(ST_FETCH));
    chk("fl_after_valid", 32'(ifid_valid), 32'd0);
    chk("fl_after_addr",  imem_addr,       32'h400);
    cycle(1'b0, 32'd0, 1'b0, RDY_ALWAYS);

    // Flush while IF/ID and the hold buffer are both full
    cycle(1'b0, 32'd0, 1'b0, RDY_ALWAYS);
    cycle(1'b0, 32'd0, 1'b1, RDY_ALWAYS);
    cycle(1'b1, 32'h600, 1'b1, RDY_ALWAYS);
    #2;
    chk("fh_state", 32'(dbg_state),    32'(ST_FETCH));
    chk("fh_valid", 32'(ifid_valid),   32'd0);
    chk("fh_hb",    32'(dbg_hb_valid), 32'd0);

    // PC wrap at 0xFFFFFFFC
    cycle(1'b1, 32'hFFFF_FFFC, 1'b0, RDY_ALWAYS);
    cycle(1'b0, 32'd0, 1'b0, RDY_ALWAYS);
    #2;
    chk("wrap_pc",  ifid_pc,  32'hFFFF_FFFC);
    chk("wrap_pc4", ifid_pc4, 32'h0000_0000);
    cycle(1'b0, 32'd0, 1'b0, RDY_ALWAYS);

    // Asynchronous reset while in DISCARD; a late ready is ignored
    cycle(1'b1, 32'h800, 1'b0, RDY_NEVER);
    #2;
    chk("rd_state", 32'(dbg_state), 32'(ST_DISCARD));
    rst        = 1'b1;
    imem_ready = 1'b1;
    #1;
    check_reset("async_rst");
    #6;
    cycle(1'b0, 32'd0, 1'b0, RDY_FORCE);
    cycle(1'b0, 32'd0, 1'b0, RDY_FORCE);
    rst = 1'b0;
    cycle(1'b0, 32'd0, 1'b0, RDY_FORCE);
    repeat (3) cycle(1'b0, 32'd0, 1'b0, RDY_ALWAYS);

    // Randomized traffic: random wait states, stalls and redirects
    for (int i = 0; i < 3000; i++) begin
      logic        fl;
      logic [31:0] tgt;
      fl  = !stale && ($urandom_range(0, 19) == 0);
      tgt = $urandom() & 32'hFFFF_FFFC;
      cycle(fl, tgt, $urandom_range(0, 2) == 0, RDY_RAND);
    end
    flush    = 1'b0;
    id_stall = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
